fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core. It owns the program counter, issues requests to instruction memory, and loads the IF/ID pipeline register with the fetched instruction and its pc_plus_four. It accepts branch redirects from decode, where branch_adder turns the IF/ID pc_plus_four into jump_address. It also handles variable-latency memory, decode stalls and wrong-path discards.

---
 rtl/fetch_stage_pkg.sv | 24 ++
 rtl/if_id_register.sv | 45 ++++
 rtl/fetch_stage.sv | 158 +++++++++++++++
 tb/tb_fetch_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the fetch FSM state encodings and the default parameter values
// (bubble encoding and reset vector) used by fetch_stage and if_id_register.
`ifndef FETCH_STAGE_PKG_SV
`define FETCH_STAGE_PKG_SV

package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FETCH_RUN     = 2'd0,
        FETCH_DISCARD = 2'd1,
        FETCH_HOLD    = 2'd2
    } fetch_state_t;

    // sll $0,$0,0 -- the canonical MIPS nop.
    localparam logic [31:0] DEFAULT_NOP_INSTRUCTION = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_VECTOR    = 32'h0000_0000;

    // Instruction fetches are always word aligned.
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

`endif

// File: rtl/if_id_register.sv
// IF/ID pipeline register.
// Ports:
//   clock, reset_n          : rising-edge clock, synchronous active-low reset
//   load                    : capture {load_instruction, load_pc_plus_four}, valid=1
//   bubble                  : insert a bubble (valid=0, NOP, pc_plus_four kept)
//   load_instruction        : instruction to capture on load
//   load_pc_plus_four       : pc+4 of that instruction
//   if_id_instruction       : registered instruction
//   if_id_pc_plus_four      : registered pc+4
//   if_id_valid             : 1 = real instruction, 0 = bubble
// With neither load nor bubble asserted the register holds. load wins if both
// are asserted, although the fetch stage never drives both at once.
module if_id_register
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTRUCTION = DEFAULT_NOP_INSTRUCTION
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] load_instruction,
    input  logic [31:0] load_pc_plus_four,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_plus_four,
    output logic        if_id_valid
);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            if_id_instruction  <= NOP_INSTRUCTION;
            if_id_pc_plus_four <= 32'h0000_0000;
            if_id_valid        <= 1'b0;
        end else if (load) begin
            if_id_instruction  <= load_instruction;
            if_id_pc_plus_four <= load_pc_plus_four;
            if_id_valid        <= 1'b1;
        end else if (bubble) begin
            // pc_plus_four is intentionally left alone in a bubble.
            if_id_instruction  <= NOP_INSTRUCTION;
            if_id_valid        <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the pipelined MIPS core.
// Owns the pc, issues instruction-memory requests and fills the IF/ID register.
// Handles variable-latency memory, decode stalls (one-entry hold buffer) and
// taken-branch redirects with wrong-path discard. No branch delay slot.
// Ports:
//   clock, reset_n      : rising-edge clock, synchronous active-low reset
//   imem_read/address   : fetch request and its word-aligned address
//   imem_data/ready     : returned instruction, completion of the request
//   stall               : decode cannot accept; IF/ID holds
//   branch_taken        : decode redirects fetch to jump_address
//   jump_address        : redirect target (bits [1:0] ignored)
//   if_id_*             : IF/ID register contents
//   debug_state         : current fetch FSM state
//
// Memory handshake: imem_read is the request valid and imem_ready completes it.
// While imem_read=1 and imem_ready=0 the request is outstanding and
// imem_address is held stable; imem_data is only sampled when imem_ready=1.
// A request is abandoned without completion only by reset, which memory shares.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR    = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] NOP_INSTRUCTION = DEFAULT_NOP_INSTRUCTION
) (
    input  logic         clock,
    input  logic         reset_n,
    output logic         imem_read,
    output logic [31:0]  imem_address,
    input  logic [31:0]  imem_data,
    input  logic         imem_ready,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [31:0]  jump_address,
    output logic [31:0]  if_id_instruction,
    output logic [31:0]  if_id_pc_plus_four,
    output logic         if_id_valid,
    output fetch_state_t debug_state
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_plus_four;
    logic [31:0]  jump_aligned;
    logic [31:0]  redirect_target;
    logic [31:0]  hold_instruction;
    logic [31:0]  hold_pc_plus_four;

    logic         ifid_load;
    logic         ifid_bubble;
    logic [31:0]  ifid_instruction;
    logic [31:0]  ifid_pc_plus_four;

    assign pc_plus_four = pc + 32'd4;   // wraps modulo 2^32
    assign jump_aligned = jump_address & WORD_MASK;
    assign debug_state  = state;

    // In DISCARD pc still names the outstanding request, so the address stays
    // stable until that request completes.
    assign imem_address = pc;
    assign imem_read    = reset_n && (state != FETCH_HOLD);

    // IF/ID control: branch first, then stall.
    always_comb begin
        ifid_load         = 1'b0;
        ifid_bubble       = 1'b0;
        ifid_instruction  = imem_data;
        ifid_pc_plus_four = pc_plus_four;
        case (state)
            FETCH_RUN: begin
                if (branch_taken) begin
                    ifid_bubble = 1'b1;
                end else if (!stall) begin
                    ifid_load   = imem_ready;
                    ifid_bubble = !imem_ready;
                end
            end
            FETCH_DISCARD: begin
                ifid_bubble = branch_taken || !stall;
            end
            FETCH_HOLD: begin
                if (branch_taken) begin
                    ifid_bubble = 1'b1;
                end else if (!stall) begin
                    ifid_load         = 1'b1;
                    ifid_instruction  = hold_instruction;
                    ifid_pc_plus_four = hold_pc_plus_four;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state             <= FETCH_RUN;
            pc                <= RESET_VECTOR & WORD_MASK;
            redirect_target   <= 32'h0000_0000;
            hold_instruction  <= 32'h0000_0000;
            hold_pc_plus_four <= 32'h0000_0000;
        end else begin
            case (state)
                FETCH_RUN: begin
                    if (branch_taken) begin
                        if (imem_ready) begin
                            pc <= jump_aligned;
                        end else begin
                            // Wrong-path request still in flight: remember
                            // where to go once it completes.
                            redirect_target <= jump_aligned;
                            state           <= FETCH_DISCARD;
                        end
                    end else if (imem_ready) begin
                        pc <= pc_plus_four;
                        if (stall) begin
                            hold_instruction  <= imem_data;
                            hold_pc_plus_four <= pc_plus_four;
                            state             <= FETCH_HOLD;
                        end
                    end
                end
                FETCH_DISCARD: begin
                    if (branch_taken) begin
                        redirect_target <= jump_aligned;
                    end
                    if (imem_ready) begin
                        // Latest redirect wins, even one arriving this cycle.
                        pc    <= branch_taken ? jump_aligned : redirect_target;
                        state <= FETCH_RUN;
                    end
                end
                FETCH_HOLD: begin
                    if (branch_taken) begin
                        pc    <= jump_aligned;
                        state <= FETCH_RUN;
                    end else if (!stall) begin
                        state <= FETCH_RUN;
                    end
                end
                default: state <= FETCH_RUN;
            endcase
        end
    end

    if_id_register #(
        .NOP_INSTRUCTION (NOP_INSTRUCTION)
    ) u_if_id_register (
        .clock              (clock),
        .reset_n            (reset_n),
        .load               (ifid_load),
        .bubble             (ifid_bubble),
        .load_instruction   (ifid_instruction),
        .load_pc_plus_four  (ifid_pc_plus_four),
        .if_id_instruction  (if_id_instruction),
        .if_id_pc_plus_four (if_id_pc_plus_four),
        .if_id_valid        (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. Instruction memory returns
// address-tagged data; expected deliveries are queued as fetches are issued
// and popped as IF/ID presents them.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic         clock = 1'b0;
    logic         reset_n;
    logic         imem_read;
    logic [31:0]  imem_address;
    logic [31:0]  imem_data;
    logic         imem_ready;
    logic         stall;
    logic         branch_taken;
    logic [31:0]  jump_address;
    logic [31:0]  if_id_instruction;
    logic [31:0]  if_id_pc_plus_four;
    logic         if_id_valid;
    fetch_state_t debug_state;

    always #5 clock = ~clock;

    fetch_stage #(
        .RESET_VECTOR    (32'h0000_0000),
        .NOP_INSTRUCTION (NOP)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .imem_read          (imem_read),
        .imem_address       (imem_address),
        .imem_data          (imem_data),
        .imem_ready         (imem_ready),
        .stall              (stall),
        .branch_taken       (branch_taken),
        .jump_address       (jump_address),
        .if_id_instruction  (if_id_instruction),
        .if_id_pc_plus_four (if_id_pc_plus_four),
        .if_id_valid        (if_id_valid),
        .debug_state        (debug_state)
    );

    // Instruction memory: data is a tag of its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_data = mem_word(imem_address);

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];   // {instruction, pc_plus_four}
    int          checks = 0;
    int          passed = 0;
    logic [64:0] got_v;
    logic [64:0] exp_v;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        imem_ready   = 1'b1;
        stall        = 1'b0;
        branch_taken = 1'b0;
        jump_address = 32'h0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        exp_q.delete();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if (if_id_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", if_id_valid);
        else passed++;
        checks++;
        if (if_id_instruction !== NOP) $display("FAIL reset_instr: got %h expected %h", if_id_instruction, NOP);
        else passed++;
        checks++;
        if (if_id_pc_plus_four !== 32'h0) $display("FAIL reset_pc4: got %h expected 0", if_id_pc_plus_four);
        else passed++;
        checks++;
        if (imem_read !== 1'b0) $display("FAIL reset_read: got %b expected 0", imem_read);
        else passed++;
        reset_n = 1'b1;
        #1;
        checks++;
        if ({imem_read, imem_address} !== {1'b1, 32'h0})
            $display("FAIL first_fetch: got read=%b addr=%h expected read=1 addr=0", imem_read, imem_address);
        else passed++;
    endtask

    task automatic test_zero_wait();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'(4 * i);
            checks++;
            if (imem_address !== a) $display("FAIL zw_addr[%0d]: got %h expected %h", i, imem_address, a);
            else passed++;
            exp_q.push_back({mem_word(a), a + 32'd4});
            step();
            checks++;
            got_v = {if_id_valid, if_id_instruction, if_id_pc_plus_four};
            exp_v = (exp_q.size() != 0) ? {1'b1, exp_q.pop_front()} : '0;
            if (got_v !== exp_v) $display("FAIL zw_deliver[%0d]: got %h expected %h", i, got_v, exp_v);
            else passed++;
        end
    endtask

    task automatic test_branch();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({mem_word(32'(4 * i)), 32'(4 * i + 4)});
            step();
            checks++;
            got_v = {if_id_valid, if_id_instruction, if_id_pc_plus_four};
            exp_v = (exp_q.size() != 0) ? {1'b1, exp_q.pop_front()} : '0;
            if (got_v !== exp_v) $display("FAIL br_pre[%0d]: got %h expected %h", i, got_v, exp_v);
            else passed++;
        end
        // Fetching 0x8 while decode redirects to 0x100.
        branch_taken = 1'b1;
        jump_address = 32'h100;
        step();
        branch_taken = 1'b0;
        checks++;
        got_v = {if_id_valid, if_id_instruction, if_id_pc_plus_four};
        exp_v = {1'b0, NOP, 32'h8};
        if (got_v !== exp_v) $display("FAIL br_bubble: got %h expected %h", got_v, exp_v);
        else passed++;
        checks++;
        if (imem_address !== 32'h100) $display("FAIL br_target: got %h expected 00000100", imem_address);
        else passed++;
        exp_q.push_back({mem_word(32'h100), 32'h104});
        step();
        checks++;
        got_v = {if_id_valid, if_id_instruction, if_id_pc_plus_four};
        exp_v = (exp_q.size() != 0) ? {1'b1, exp_q.pop_front()} : '0;
        if (got_v !== exp_v) $display("FAIL br_deliver: got %h expected %h", got_v, exp_v);
        else passed++;
    endtask

    task automatic test_latency();
        apply_reset();
        // Plain latency 3 on address 0: two bubbles, then delivery.
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({if_id_valid, imem_read, imem_address} !== {1'b0, 1'b1, 32'h0})
                $display("FAIL lat_wait[%0d]: got valid=%b read=%b addr=%h expected 0/1/0", i, if_id_valid, imem_read, imem_address);
            else passed++;
        end
        imem_ready = 1'b1;
        exp_q.push_back({mem_word(32'h0), 32'h4});
        step();
        checks++;
        got_v = {if_id_valid, if_id_instruction, if_id_pc_plus_four};
        exp_v = (exp_q.size() != 0) ? {1'b1, exp_q.pop_front()} : '0;
        if (got_v !== exp_v) $display("FAIL lat_deliver: got %h expected %h", got_v, exp_v);
        else passed++;
        // Latency 3 on address 4 with a redirect in the first wait cycle.
        imem_ready   = 1'b0;
        branch_taken = 1'b1;
        jump_address = 32'h202;   // low bits must be ignored
        step();
        branch_taken = 1'b0;
        checks++;
        if (debug_state !== FETCH_DISCARD) $display("FAIL lat_discard_state: got %0d expected %0d", debug_state, FETCH_DISCARD);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({imem_read, imem_address} !== {1'b1, 32'h4})
                $display("FAIL lat_stable[%0d]: got read=%b addr=%h expected 1/4", i, imem_read, imem_address);
            else passed++;
            imem_ready = (i == 1);
            step();
            checks++;
            if (if_id_valid !== 1'b0) $display("FAIL lat_no_wrong_path[%0d]: got %b expected 0", i, if_id_valid);
            else passed++;
        end
        checks++;
        if (imem_address !== 32'h200) $display("FAIL lat_target: got %h expected 00000200", imem_address);
        else passed++;
        imem_ready = 1'b1;
        exp_q.push_back({mem_word(32'h200), 32'h204});
        step();
        checks++;
        got_v = {if_id_valid, if_id_instruction, if_id_pc_plus_four};
        exp_v = (exp_q.size() != 0) ? {1'b1, exp_q.pop_front()} : '0;
        if (got_v !== exp_v) $display("FAIL lat_target_deliver: got %h expected %h", got_v, exp_v);
        else passed++;
    endtask

    task automatic test_stall();
        logic [64:0] held;
        apply_reset();
        exp_q.push_back({mem_word(32'h0), 32'h4});
        step();
        checks++;
        got_v = {if_id_valid, if_id_instruction, if_id_pc_plus_four};
        exp_v = (exp_q.size() != 0) ? {1'b1, exp_q.pop_front()} : '0;
        if (got_v !== exp_v) $display("FAIL st_first: got %h expected %h", got_v, exp_v);
        else passed++;
        held = {1'b1, mem_word(32'h0), 32'h4};
        // Fetch of 0x4 completes while stalled; stall lasts four cycles.
        stall = 1'b1;
        exp_q.push_back({mem_word(32'h4), 32'h8});
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            got_v = {if_id_valid, if_id_instruction, if_id_pc_plus_four};
            if (got_v !== held) $display("FAIL st_hold[%0d]: got %h expected %h", i, got_v, held);
            else passed++;
            checks++;
            if (imem_read !== 1'b0) $display("FAIL st_read[%0d]: got %b expected 0", i, imem_read);
            else passed++;
        end
        stall = 1'b0;
        step();
        checks++;
        got_v = {if_id_valid, if_id_instruction, if_id_pc_plus_four};
        exp_v = (exp_q.size() != 0) ? {1'b1, exp_q.pop_front()} : '0;
        if (got_v !== exp_v) $display("FAIL st_buffer: got %h expected %h", got_v, exp_v);
        else passed++;
        checks++;
        if ({imem_read, imem_address} !== {1'b1, 32'h8})
            $display("FAIL st_resume: got read=%b addr=%h expected 1/8", imem_read, imem_address);
        else passed++;
        exp_q.push_back({mem_word(32'h8), 32'hC});
        step();
        checks++;
        got_v = {if_id_valid, if_id_instruction, if_id_pc_plus_four};
        exp_v = (exp_q.size() != 0) ? {1'b1, exp_q.pop_front()} : '0;
        if (got_v !== exp_v) $display("FAIL st_after: got %h expected %h", got_v, exp_v);
        else passed++;
    endtask

    task automatic test_wrap();
        apply_reset();
        branch_taken = 1'b1;
        jump_address = 32'hFFFF_FFFF;
        step();
        branch_taken = 1'b0;
        checks++;
        if (imem_address !== 32'hFFFF_FFFC) $display("FAIL wrap_addr: got %h expected fffffffc", imem_address);
        else passed++;
        exp_q.push_back({mem_word(32'hFFFF_FFFC), 32'h0});
        step();
        checks++;
        got_v = {if_id_valid, if_id_instruction, if_id_pc_plus_four};
        exp_v = (exp_q.size() != 0) ? {1'b1, exp_q.pop_front()} : '0;
        if (got_v !== exp_v) $display("FAIL wrap_deliver: got %h expected %h", got_v, exp_v);
        else passed++;
        checks++;
        if (imem_address !== 32'h0) $display("FAIL wrap_next: got %h expected 00000000", imem_address);
        else passed++;
    endtask

    task automatic test_reset_mid();
        // Reset while in DISCARD.
        apply_reset();
        imem_ready   = 1'b0;
        branch_taken = 1'b1;
        jump_address = 32'h300;
        step();
        branch_taken = 1'b0;
        checks++;
        if (debug_state !== FETCH_DISCARD) $display("FAIL rd_state: got %0d expected %0d", debug_state, FETCH_DISCARD);
        else passed++;
        reset_n = 1'b0;
        step();
        reset_n    = 1'b1;
        imem_ready = 1'b1;
        #1;
        checks++;
        if ({imem_read, imem_address, if_id_valid} !== {1'b1, 32'h0, 1'b0})
            $display("FAIL rd_refetch: got read=%b addr=%h valid=%b expected 1/0/0", imem_read, imem_address, if_id_valid);
        else passed++;
        exp_q.push_back({mem_word(32'h0), 32'h4});
        step();
        checks++;
        got_v = {if_id_valid, if_id_instruction, if_id_pc_plus_four};
        exp_v = (exp_q.size() != 0) ? {1'b1, exp_q.pop_front()} : '0;
        if (got_v !== exp_v) $display("FAIL rd_no_redirect: got %h expected %h", got_v, exp_v);
        else passed++;
        // Reset while in HOLD.
        apply_reset();
        stall = 1'b1;
        step();
        checks++;
        if (debug_state !== FETCH_HOLD) $display("FAIL rh_state: got %0d expected %0d", debug_state, FETCH_HOLD);
        else passed++;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        stall   = 1'b0;
        #1;
        checks++;
        if ({imem_read, imem_address, if_id_valid} !== {1'b1, 32'h0, 1'b0})
            $display("FAIL rh_refetch: got read=%b addr=%h valid=%b expected 1/0/0", imem_read, imem_address, if_id_valid);
        else passed++;
        exp_q.push_back({mem_word(32'h0), 32'h4});
        step();
        checks++;
        got_v = {if_id_valid, if_id_instruction, if_id_pc_plus_four};
        exp_v = (exp_q.size() != 0) ? {1'b1, exp_q.pop_front()} : '0;
        if (got_v !== exp_v) $display("FAIL rh_deliver: got %h expected %h", got_v, exp_v);
        else passed++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_zero_wait();
        test_branch();
        test_latency();
        test_stall();
        test_wrap();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
